uart_tx_ctrl: RTL and testbench

UART transmit sequencer. Pops bytes from the read side of the TX async FIFO in the `clk` domain and serializes each byte onto the `tx` line. Frames are LSB-first, with optional parity and 1 or 2 stop bits, timed by a programmable baud divider. It sits between the APB-fed TX FIFO and the UART pad, and owns the FIFO pop handshake.

---
 rtl/uart_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from a first-word-fall-through FIFO and
// serialises them LSB-first with optional parity and one or two stop bits.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_tx_en_i,
  input  logic [BAUD_DIV_WIDTH-1:0] cfg_baud_div_i,
  input  logic                      cfg_parity_en_i,
  input  logic                      cfg_parity_odd_i,
  input  logic                      cfg_stop2_i,
  input  logic                      fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]     fifo_data_i,
  output logic                      fifo_rd_req_o,
  output logic                      tx_o,
  output logic                      tx_busy_o,
  output logic                      tx_done_o
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] CntOne = BAUD_DIV_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                    state_q, state_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_DIV_WIDTH-1:0] div_q, div_d;
  logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      stop_idx_q, stop_idx_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      stop2_q, stop2_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic bit_end;
  logic last_stop;
  logic pop;

  always_comb begin
    bit_end   = (baud_cnt_q == '0);
    last_stop = (state_q == StStop) && bit_end && (stop_idx_q == stop2_q);
    pop       = ~reset_i & cfg_tx_en_i & ~fifo_empty_i & ((state_q == StIdle) | last_stop);
  end

  assign fifo_rd_req_o = pop;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    baud_cnt_d = ((state_q != StIdle) && !bit_end) ? (baud_cnt_q - CntOne) : baud_cnt_q;

    if (pop) begin
      // Frame config is latched here so mid-frame cfg writes wait for the next pop.
      state_d    = StStart;
      baud_cnt_d = cfg_baud_div_i;
      div_d      = cfg_baud_div_i;
      shift_d    = fifo_data_i;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      par_en_d   = cfg_parity_en_i;
      par_bit_d  = (^fifo_data_i) ^ cfg_parity_odd_i;
      stop2_d    = cfg_stop2_i;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          if (bit_end) begin
            state_d    = StData;
            baud_cnt_d = div_q;
            bit_idx_d  = '0;
            tx_d       = shift_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            baud_cnt_d = div_q;
            if (bit_idx_q == LastIdx) begin
              if (par_en_q) begin
                state_d = StParity;
                tx_d    = par_bit_q;
              end else begin
                state_d    = StStop;
                stop_idx_d = 1'b0;
                tx_d       = 1'b1;
              end
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_d    = StStop;
            baud_cnt_d = div_q;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
          end
        end
        StStop: begin
          if (last_stop) begin
            state_d    = StIdle;
            baud_cnt_d = '0;
            busy_d     = 1'b0;
            tx_d       = 1'b1;
          end else if (bit_end) begin
            stop_idx_d = 1'b1;
            baud_cnt_d = div_q;
          end
        end
        default: begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end

    // Registered done: flag the cycle that will be the final stop-bit cycle.
    done_d = (state_d == StStop) && (baud_cnt_d == '0) && (stop_idx_d == stop2_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle trace compared against a
// frame-level model, plus hand-derived table constants and corner sequences.
module tb_uart_tx_ctrl;
  localparam int DW = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_tx_en = 1'b0;
  logic [BW-1:0] cfg_baud_div = '0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_req, tx, tx_busy, tx_done;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .BAUD_DIV_WIDTH(BW)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .cfg_tx_en_i     (cfg_tx_en),
    .cfg_baud_div_i  (cfg_baud_div),
    .cfg_parity_en_i (cfg_parity_en),
    .cfg_parity_odd_i(cfg_parity_odd),
    .cfg_stop2_i     (cfg_stop2),
    .fifo_empty_i    (fifo_empty),
    .fifo_data_i     (fifo_data),
    .fifo_rd_req_o   (fifo_rd_req),
    .tx_o            (tx),
    .tx_busy_o       (tx_busy),
    .tx_done_o       (tx_done)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par_en;
    bit         odd;
    bit         stop2;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par_en;
    bit         odd;
    bit         stop2;
    int         exp_par;  // -1 when no parity bit is sent
    int         exp_len;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [7:0] fifo_q[$];
  frame_t     frames[$];
  logic       exp_tx[$], exp_busy[$], exp_done[$], exp_req[$];
  logic       got_tx[$], got_busy[$], got_done[$], got_req[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // Sample on the falling edge, apply the FIFO pop just after the rising edge.
  task automatic cyc(output logic s_tx, output logic s_busy, output logic s_done,
                     output logic s_req);
    @(negedge clk);
    s_tx   = tx;
    s_busy = tx_busy;
    s_done = tx_done;
    s_req  = fifo_rd_req;
    @(posedge clk);
    #1;
    if (s_req && !reset && fifo_q.size() > 0) fifo_q.delete(0);
    refresh();
  endtask

  function automatic int flen(input frame_t f);
    return (1 + 8 + int'(f.par_en) + 1 + int'(f.stop2)) * (f.div + 1);
  endfunction

  // Expected waveform: pop in cycle 0, then frames laid end to end, then idle.
  task automatic build(input int ncyc);
    exp_tx.delete(); exp_busy.delete(); exp_done.delete(); exp_req.delete();
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    exp_done.push_back(1'b0); exp_req.push_back(frames.size() > 0);
    for (int i = 0; i < frames.size(); i++) begin
      logic bits[$];
      int   len;
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(frames[i].data[k]);
      if (frames[i].par_en)
        bits.push_back(logic'(($countones(frames[i].data) % 2) != 0) ^ frames[i].odd);
      bits.push_back(1'b1);
      if (frames[i].stop2) bits.push_back(1'b1);
      len = flen(frames[i]);
      for (int t = 0; t < len; t++) begin
        exp_tx.push_back(bits[t / (frames[i].div + 1)]);
        exp_busy.push_back(1'b1);
        exp_done.push_back(t == len - 1);
        exp_req.push_back((t == len - 1) && (i < frames.size() - 1));
      end
    end
    while (exp_tx.size() < ncyc) begin
      exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0); exp_req.push_back(1'b0);
    end
  endtask

  task automatic run_check(input string name, input int ncyc, input int en_drop_at,
                           input int div_at, input int new_div);
    logic a, b, c, d;
    build(ncyc);
    got_tx.delete(); got_busy.delete(); got_done.delete(); got_req.delete();
    for (int cy = 0; cy < ncyc; cy++) begin
      if (cy == en_drop_at) cfg_tx_en = 1'b0;
      if (cy == div_at) cfg_baud_div = BW'(new_div);
      cyc(a, b, c, d);
      got_tx.push_back(a); got_busy.push_back(b);
      got_done.push_back(c); got_req.push_back(d);
      check($sformatf("%s c%0d tx,busy,done,req", name, cy), {28'd0, a, b, c, d},
            {28'd0, exp_tx[cy], exp_busy[cy], exp_done[cy], exp_req[cy]});
    end
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit odd, input bit s2);
    cfg_baud_div   = BW'(div);
    cfg_parity_en  = pe;
    cfg_parity_odd = odd;
    cfg_stop2      = s2;
  endtask

  function automatic frame_t mk(input logic [7:0] d, input int div, input bit pe,
                                input bit odd, input bit s2);
    frame_t f;
    f.data = d; f.div = div; f.par_en = pe; f.odd = odd; f.stop2 = s2;
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    logic a, b, c, d;
    int   cnt, pidx[$];

    vecs.push_back('{8'h55, 3, 1'b0, 1'b0, 1'b0, -1, 40});
    vecs.push_back('{8'h07, 0, 1'b1, 1'b0, 1'b0,  1, 11});
    vecs.push_back('{8'h07, 0, 1'b1, 1'b1, 1'b0,  0, 11});
    vecs.push_back('{8'hA5, 1, 1'b1, 1'b0, 1'b1,  0, 24});
    vecs.push_back('{8'h3C, 1, 1'b0, 1'b0, 1'b1, -1, 22});
    vecs.push_back('{8'h00, 2, 1'b1, 1'b1, 1'b0,  1, 33});
    vecs.push_back('{8'hFF, 0, 1'b1, 1'b1, 1'b1,  1, 12});

    @(posedge clk);
    #1;
    check("reset tx", tx, 1'b1);
    check("reset busy", tx_busy, 1'b0);
    check("reset done", tx_done, 1'b0);
    check("reset rd_req", fifo_rd_req, 1'b0);
    reset = 1'b0;
    cyc(a, b, c, d);

    // Table-driven single frames.
    cfg_tx_en = 1'b1;
    foreach (vecs[i]) begin
      set_cfg(vecs[i].div, vecs[i].par_en, vecs[i].odd, vecs[i].stop2);
      frames.delete();
      frames.push_back(mk(vecs[i].data, vecs[i].div, vecs[i].par_en, vecs[i].odd,
                          vecs[i].stop2));
      push(vecs[i].data);
      run_check($sformatf("vec%0d", i), vecs[i].exp_len + 3, -1, -1, 0);
      cnt = 0;
      foreach (got_busy[k]) cnt += int'(got_busy[k]);
      check($sformatf("vec%0d busy cycles", i), cnt, vecs[i].exp_len);
      check($sformatf("vec%0d done pos", i), got_done[vecs[i].exp_len], 1'b1);
      if (vecs[i].exp_par >= 0)
        check($sformatf("vec%0d parity bit", i), got_tx[1 + 9 * (vecs[i].div + 1)],
              vecs[i].exp_par[0]);
    end

    // Back-to-back frames with parity and two stop bits.
    set_cfg(1, 1'b1, 1'b0, 1'b1);
    frames.delete();
    frames.push_back(mk(8'hA5, 1, 1'b1, 1'b0, 1'b1));
    frames.push_back(mk(8'h3C, 1, 1'b1, 1'b0, 1'b1));
    push(8'hA5);
    push(8'h3C);
    run_check("b2b", 52, -1, -1, 0);
    pidx.delete();
    foreach (got_req[k]) if (got_req[k]) pidx.push_back(k);
    check("b2b pop count", pidx.size(), 2);
    if (pidx.size() == 2) check("b2b pop spacing", pidx[1] - pidx[0], 24);
    cnt = 0;
    for (int k = 1; k <= 48; k++) cnt += int'(got_busy[k]);
    check("b2b busy continuous", cnt, 48);

    // Empty FIFO with enable, then data with enable low.
    frames.delete();
    run_check("empty", 30, -1, -1, 0);
    cfg_tx_en = 1'b0;
    push(8'h81);
    run_check("disabled", 30, -1, -1, 0);
    check("disabled fifo kept", fifo_q.size(), 1);
    cfg_tx_en = 1'b1;
    frames.push_back(mk(8'h81, 1, 1'b1, 1'b0, 1'b1));
    run_check("enable drain", 30, -1, -1, 0);

    // Enable dropped during DATA: frame finishes, second byte stays queued.
    set_cfg(2, 1'b0, 1'b0, 1'b0);
    frames.delete();
    frames.push_back(mk(8'h96, 2, 1'b0, 1'b0, 1'b0));
    push(8'h96);
    push(8'h69);
    run_check("endrop", 45, 1 + 3 * 3, -1, 0);
    check("endrop fifo left", fifo_q.size(), 1);
    cfg_tx_en = 1'b1;
    frames.delete();
    frames.push_back(mk(8'h69, 2, 1'b0, 1'b0, 1'b0));
    run_check("endrop drain", 36, -1, -1, 0);

    // Reset during bit 3 of 0x00, then a clean frame after release.
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    for (int k = 0; k < 18; k++) cyc(a, b, c, d);
    check("pre-reset tx low", tx, 1'b0);
    reset = 1'b1;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset busy", tx_busy, 1'b0);
    check("async reset done", tx_done, 1'b0);
    push(8'h5A);
    check("reset rd_req forced", fifo_rd_req, 1'b0);
    cyc(a, b, c, d);
    cyc(a, b, c, d);
    check("in reset no pop", d, 1'b0);
    reset = 1'b0;
    frames.delete();
    frames.push_back(mk(8'h5A, 3, 1'b0, 1'b0, 1'b0));
    run_check("post reset", 44, -1, -1, 0);

    // Divider change mid-frame applies only to the next frame.
    set_cfg(3, 1'b0, 1'b0, 1'b0);
    frames.delete();
    frames.push_back(mk(8'h33, 3, 1'b0, 1'b0, 1'b0));
    frames.push_back(mk(8'hCC, 7, 1'b0, 1'b0, 1'b0));
    push(8'h33);
    push(8'hCC);
    run_check("cfgchg", 1 + 40 + 80 + 3, -1, 10, 7);

    // Randomised frame groups.
    for (int r = 0; r < 15; r++) begin
      int n, div, ncyc;
      bit pe, odd, s2;
      n   = $urandom_range(1, 3);
      div = $urandom_range(0, 4);
      pe  = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      set_cfg(div, pe, odd, s2);
      frames.delete();
      ncyc = 4;
      for (int k = 0; k < n; k++) begin
        logic [7:0] byt;
        byt = 8'($urandom);
        frames.push_back(mk(byt, div, pe, odd, s2));
        push(byt);
        ncyc += flen(frames[k]);
      end
      run_check($sformatf("rand%0d", r), ncyc, -1, -1, 0);
    end

    check("fifo drained", fifo_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
